ramb_tdp_param: RTL
===================

Name: ramb_tdp_param

Overview:
Parametrised single-clock true dual-port block RAM, successor to the fixed-geometry 2-bit dual-port primitives. Width, depth, byte-write granularity, per-port write mode and optional output pipeline register are generics. Deterministic collision resolution is built in, with a registered collision flag and a saturating collision counter. Instantiated by datapath buffers and lookup tables that previously chained fixed primitives.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH words.
BYTE_WIDTH, 8, write-enable granularity; NBE = DATA_WIDTH/BYTE_WIDTH.
WRITE_MODE_A, "WRITE_FIRST", port A mode: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
WRITE_MODE_B, "WRITE_FIRST", port B mode, same encoding as WRITE_MODE_A.
DO_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2.
SRVAL_A, 0, DOA value on reset (DATA_WIDTH bits).
SRVAL_B, 0, DOB value on reset.
INIT, 0, flattened DEPTH*DATA_WIDTH initial contents; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
SIM_COLLISION_CHECK, "ALL", "ALL" enables COLLISION/COLL_CNT; "NONE" ties both to 0.

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
ENA  input  1  port A enable
WEA  input  NBE  port A byte write enables
ADDRA  input  ADDR_WIDTH  port A address
DIA  input  DATA_WIDTH  port A write data
DOA  output  DATA_WIDTH  port A read data
ENB  input  1  port B enable
WEB  input  NBE  port B byte write enables
ADDRB  input  ADDR_WIDTH  port B address
DIB  input  DATA_WIDTH  port B write data
DOB  output  DATA_WIDTH  port B read data
COLLISION  output  1  one-cycle pulse, collision in previous cycle
COLL_CNT  output  8  saturating collision count

Behaviour:
- Memory powers up with INIT contents. RST never alters memory contents.
- Port x is active when ENx=1. Inactive port: no write, and its first output stage holds.
- Write: for each byte k with WEx[k]=1, mem[ADDRx] byte k <= DIx byte k on the clock edge.
- First output stage (latched on the edge when ENx=1):
  - Any WEx bit = 0: stage <= mem[ADDRx].
  - Writing, WRITE_FIRST: stage <= merged word (new bytes where WEx=1, old bytes elsewhere).
  - Writing, READ_FIRST: stage <= old word.
  - Writing, NO_CHANGE: stage holds.
- DO_REG=0: DOx = first stage; latency 1.
- DO_REG=1: second stage <= first stage every clock, independent of EN; DOx = second stage; latency 2.
- Collision condition: ENA & ENB & (ADDRA==ADDRB) & (|WEA | |WEB).
  - Write/write: per byte, if both ports enable the byte, port A data is stored; otherwise each enabled byte is stored from its own port.
  - Port-own output follows its WRITE_MODE, using the merged result actually stored.
  - Read-only port in a collision returns the old word, regardless of its mode.
- COLLISION: registered; =1 in the cycle after the collision condition, else 0.
- COLL_CNT: increments by 1 per collision cycle and saturates at 255 (no wrap).
- RST=1 at a clock edge:
  - Both output stages of each port <= SRVAL_x; COLLISION <= 0; COLL_CNT <= 0.
  - Reset overrides EN and overrides collision counting that cycle.
  - Writes presented in that cycle still update memory.
- Reset mid-read: a read issued in the reset cycle is lost; DOx shows SRVAL_x. A read issued one cycle before reset with DO_REG=1 is also overwritten by SRVAL_x.
- Address wrap is implicit: the full 2**ADDR_WIDTH range is valid and there is no out-of-range case.

Test Plan:
- Defaults, INIT word 5 = 8'hA5: RST, then ENA=1, WEA=0, ADDRA=5 -> DOA=8'h00 during reset, 8'hA5 one cycle after the read edge.
- Mode matrix, mem[3]=8'h11: port A writes 8'h22 to address 3 with WRITE_FIRST / READ_FIRST / NO_CHANGE -> DOA = 8'h22 / 8'h11 / previous DOA; subsequent read returns 8'h22 in all modes.
- DATA_WIDTH=16, BYTE_WIDTH=8, mem[7]=16'hAAAA: WEA=2'b01, DIA=16'h1234 -> mem[7]=16'hAA34; WRITE_FIRST DOA=16'hAA34.
- Write/write collision at address 9: A writes 8'h5A (WEA=1), B writes 8'hC3 (WEB=1) -> mem[9]=8'h5A; COLLISION=1 for exactly one cycle, next cycle; COLL_CNT=1.
- Read/write collision: A writes 8'h77 to address 2 (old 8'h10) while B reads address 2 -> DOB=8'h10; 300 consecutive collisions -> COLL_CNT stops at 255.
- DO_REG=1, SRVAL_B=8'hFF: B reads address 4 (8'h3C) -> DOB=8'h3C two cycles later; RST asserted the cycle after the read -> DOB=8'hFF, and 8'h3C never appears.

Source files
------------

// File: rtl/ramb_tdp_param.sv
`default_nettype none
// ============================================================================
//  Module      : ramb_tdp_param
//  Description : Parametrised single-clock true dual-port block RAM with byte
//                write enables, per-port write mode, optional output register
//                and deterministic collision resolution (port A wins on
//                shared bytes), collision pulse and saturating counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ramb_tdp_param #(
    parameter int                                       DATA_WIDTH          = 8,
    parameter int                                       ADDR_WIDTH          = 9,
    parameter int                                       BYTE_WIDTH          = 8,
    parameter string                                    WRITE_MODE_A        = "WRITE_FIRST",
    parameter string                                    WRITE_MODE_B        = "WRITE_FIRST",
    parameter int                                       DO_REG              = 0,
    parameter logic [DATA_WIDTH-1:0]                    SRVAL_A             = '0,
    parameter logic [DATA_WIDTH-1:0]                    SRVAL_B             = '0,
    parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    INIT                = '0,
    parameter string                                    SIM_COLLISION_CHECK = "ALL"
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 ENA,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     WEA,
    input  logic [ADDR_WIDTH-1:0]                ADDRA,
    input  logic [DATA_WIDTH-1:0]                DIA,
    output logic [DATA_WIDTH-1:0]                DOA,
    input  logic                                 ENB,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     WEB,
    input  logic [ADDR_WIDTH-1:0]                ADDRB,
    input  logic [DATA_WIDTH-1:0]                DIB,
    output logic [DATA_WIDTH-1:0]                DOB,
    output logic                                 COLLISION,
    output logic [7:0]                           COLL_CNT
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;

    localparam bit A_WRITE_FIRST = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit A_READ_FIRST  = (WRITE_MODE_A == "READ_FIRST");
    localparam bit B_WRITE_FIRST = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit B_READ_FIRST  = (WRITE_MODE_B == "READ_FIRST");

    // Storage powers up with the INIT image; reset never touches it.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem = INIT;

    logic [DATA_WIDTH-1:0] old_a;
    logic [DATA_WIDTH-1:0] old_b;
    logic [DATA_WIDTH-1:0] store_a;
    logic [DATA_WIDTH-1:0] store_b;
    logic [DATA_WIDTH-1:0] stage1_a;
    logic [DATA_WIDTH-1:0] stage1_b;
    logic                  same_addr;
    logic                  write_a;
    logic                  write_b;
    logic                  coll_cond;

    assign old_a     = mem[ADDRA];
    assign old_b     = mem[ADDRB];
    assign same_addr = (ADDRA == ADDRB);
    assign write_a   = ENA && (|WEA);
    assign write_b   = ENB && (|WEB);
    assign coll_cond = ENA && ENB && same_addr && ((|WEA) || (|WEB));

    // Merged word each port would store; on a shared address both merges are
    // identical (A overrides B byte-wise), so two word writes never disagree.
    always_comb begin
        store_a = old_a;
        store_b = old_b;
        for (int k = 0; k < NBE; k++) begin
            if (ENB && WEB[k] && same_addr) store_a[k*BYTE_WIDTH +: BYTE_WIDTH] = DIB[k*BYTE_WIDTH +: BYTE_WIDTH];
            if (ENA && WEA[k])              store_a[k*BYTE_WIDTH +: BYTE_WIDTH] = DIA[k*BYTE_WIDTH +: BYTE_WIDTH];
            if (ENB && WEB[k])              store_b[k*BYTE_WIDTH +: BYTE_WIDTH] = DIB[k*BYTE_WIDTH +: BYTE_WIDTH];
            if (ENA && WEA[k] && same_addr) store_b[k*BYTE_WIDTH +: BYTE_WIDTH] = DIA[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Memory write; writes land even while RST is asserted.
    always_ff @(posedge CLK) begin
        if (write_b) mem[ADDRB] <= store_b;
        if (write_a) mem[ADDRA] <= store_a;
    end

    // Port A first output stage: read, or write-mode-dependent capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage1_a <= SRVAL_A;
        end else if (ENA) begin
            if (!(|WEA))          stage1_a <= old_a;
            else if (A_WRITE_FIRST) stage1_a <= store_a;
            else if (A_READ_FIRST)  stage1_a <= old_a;
        end
    end

    // Port B first output stage: read, or write-mode-dependent capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage1_b <= SRVAL_B;
        end else if (ENB) begin
            if (!(|WEB))          stage1_b <= old_b;
            else if (B_WRITE_FIRST) stage1_b <= store_b;
            else if (B_READ_FIRST)  stage1_b <= old_b;
        end
    end

    generate
        if (DO_REG != 0) begin : g_do_reg
            logic [DATA_WIDTH-1:0] stage2_a;
            logic [DATA_WIDTH-1:0] stage2_b;

            // Free-running second stage; reset also flushes an in-flight read.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    stage2_a <= SRVAL_A;
                    stage2_b <= SRVAL_B;
                end else begin
                    stage2_a <= stage1_a;
                    stage2_b <= stage1_b;
                end
            end

            assign DOA = stage2_a;
            assign DOB = stage2_b;
        end else begin : g_no_do_reg
            assign DOA = stage1_a;
            assign DOB = stage1_b;
        end
    endgenerate

    generate
        if (SIM_COLLISION_CHECK == "ALL") begin : g_coll
            logic       coll_q;
            logic [7:0] cnt_q;

            // Registered collision pulse and saturating collision counter.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    coll_q <= 1'b0;
                    cnt_q  <= 8'd0;
                end else begin
                    coll_q <= coll_cond;
                    if (coll_cond && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
                end
            end

            assign COLLISION = coll_q;
            assign COLL_CNT  = cnt_q;
        end else begin : g_no_coll
            assign COLLISION = 1'b0;
            assign COLL_CNT  = 8'd0;
        end
    endgenerate

endmodule
`default_nettype wire
